// File: rtl/mem_tester_pkg.sv
// Shared definitions for the SRAM soak tester: pattern modes, FSM encoding
// and the 20-bit LFSR used to generate pseudo-random data.
package mem_tester_pkg;

  localparam int LFSR_W = 20;
  // Feedback from bits 19 and 16 (x^20 + x^17 + 1).
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 20'h90000;

  localparam logic [1:0] PAT_LFSR  = 2'd0;
  localparam logic [1:0] PAT_ADDR  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_WALK1 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_START = 3'd1,
    ST_WR_WAIT  = 3'd2,
    ST_RD_START = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_PASS_END = 3'd5,
    ST_HALT     = 3'd6
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mem_pattern_gen.sv
// Data pattern generator shared by the write and compare phases: an LFSR
// that steps once per transferred word, plus the per-mode pattern mux.
module mem_pattern_gen
  import mem_tester_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 19,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 20'h1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [1:0]        mode,
  input  logic              inv,
  input  logic [ADDR_W-1:0] idx,
  output logic [DATA_W-1:0] data
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [DATA_W-1:0] raw;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = LFSR_SEED;
    end else if (step) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  always_comb begin
    raw = '0;
    case (mode)
      PAT_LFSR:  raw = DATA_W'(lfsr_q);
      PAT_ADDR:  raw = DATA_W'(idx);
      PAT_CHECK: begin
        // Even words give 0xAA.., odd words 0x55..; an odd top bit stays 0.
        for (int i = 0; i < (DATA_W / 2) * 2; i++) begin
          raw[i] = (i % 2 == 0) ? idx[0] : ~idx[0];
        end
      end
      default:   raw = DATA_W'(1) << (int'(idx) % DATA_W);
    endcase
  end

  assign data = raw ^ {DATA_W{inv}};

endmodule

// File: rtl/mem_pattern_tester.sv
// SRAM soak tester: endlessly fills the array with a pattern and reads it
// back, counting mismatches, capturing the first one and counting passes.
module mem_pattern_tester
  import mem_tester_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 19,
  parameter int                ERRCNT_W  = 16,
  parameter int                PASSCNT_W = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 20'h1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [1:0]           mode,
  input  logic                 invert_odd,
  input  logic                 stop_on_err,
  input  logic                 clr,
  output logic                 sram_start,
  output logic                 sram_rnw,
  input  logic                 sram_stop,
  input  logic                 sram_ready,
  output logic [DATA_W-1:0]    sram_wdat,
  input  logic [DATA_W-1:0]    sram_rdat,
  output logic                 busy,
  output logic                 halted,
  output logic [ERRCNT_W-1:0]  err_cnt,
  output logic [PASSCNT_W-1:0] pass_cnt,
  output logic [ADDR_W-1:0]    err_addr,
  output logic [DATA_W-1:0]    err_exp,
  output logic [DATA_W-1:0]    err_got,
  output logic                 led,
  output logic [2:0]           dbg_state
);

  // Controller handshake: sram_start is a one-cycle request qualified by
  // sram_rnw; each sram_ready transfers exactly one word (write accepted or
  // read data valid on sram_rdat in that cycle) and sram_stop marks the last.

  state_t state_q, state_d;

  logic [ADDR_W-1:0]    idx_q, idx_d;
  logic [1:0]           mode_q, mode_d;
  logic                 inv_q, inv_d;
  logic                 parity_q, parity_d;
  logic                 mis_q, mis_d;
  logic [ADDR_W-1:0]    mis_idx_q, mis_idx_d;
  logic [DATA_W-1:0]    mis_exp_q, mis_exp_d;
  logic [DATA_W-1:0]    mis_got_q, mis_got_d;
  logic [ERRCNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [PASSCNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [ADDR_W-1:0]    err_addr_q, err_addr_d;
  logic [DATA_W-1:0]    err_exp_q, err_exp_d;
  logic [DATA_W-1:0]    err_got_q, err_got_d;
  logic                 led_q, led_d;

  logic              in_start;
  logic              wr_phase;
  logic              xfer;
  logic              rd_xfer;
  logic              halt_req;
  logic [DATA_W-1:0] gen_data;

  assign in_start = (state_q == ST_WR_START) || (state_q == ST_RD_START);
  assign wr_phase = (state_q == ST_WR_START) || (state_q == ST_WR_WAIT);
  assign xfer     = sram_ready && ((state_q == ST_WR_WAIT) || (state_q == ST_RD_WAIT));
  assign rd_xfer  = sram_ready && (state_q == ST_RD_WAIT);
  assign halt_req = mis_q && stop_on_err && !clr;

  mem_pattern_gen #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .LFSR_SEED(LFSR_SEED)
  ) u_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .load (in_start),
    .step (xfer),
    .mode (mode_q),
    .inv  (inv_q && parity_q),
    .idx  (idx_q),
    .data (gen_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (run) state_d = ST_WR_START;
      ST_WR_START: state_d = ST_WR_WAIT;
      ST_WR_WAIT:  if (sram_stop) state_d = ST_RD_START;
      ST_RD_START: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (halt_req) state_d = ST_HALT;
        else if (sram_stop) state_d = ST_PASS_END;
      end
      // A mismatch on the final word is only registered here.
      ST_PASS_END: begin
        if (halt_req) state_d = ST_HALT;
        else if (run) state_d = ST_WR_START;
        else state_d = ST_IDLE;
      end
      ST_HALT:     if (clr) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_d      = idx_q;
    mode_d     = mode_q;
    inv_d      = inv_q;
    parity_d   = parity_q;
    mis_d      = 1'b0;
    mis_idx_d  = mis_idx_q;
    mis_exp_d  = mis_exp_q;
    mis_got_d  = mis_got_q;
    err_cnt_d  = err_cnt_q;
    pass_cnt_d = pass_cnt_q;
    err_addr_d = err_addr_q;
    err_exp_d  = err_exp_q;
    err_got_d  = err_got_q;
    led_d      = led_q;

    if (in_start) begin
      idx_d = '0;
    end else if (xfer) begin
      idx_d = idx_q + ADDR_W'(1);
    end

    if (state_q == ST_WR_START) begin
      mode_d = mode;
      inv_d  = invert_odd;
    end

    if (rd_xfer) begin
      mis_d     = (sram_rdat != gen_data);
      mis_idx_d = idx_q;
      mis_exp_d = gen_data;
      mis_got_d = sram_rdat;
    end

    if (state_q == ST_PASS_END) begin
      parity_d   = ~parity_q;
      pass_cnt_d = pass_cnt_q + PASSCNT_W'(1);
      led_d      = ~led_q;
    end

    // Counter and capture act one cycle after the compare.
    if (mis_q) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERRCNT_W'(1);
      if (err_cnt_q == '0) begin
        err_addr_d = mis_idx_q;
        err_exp_d  = mis_exp_q;
        err_got_d  = mis_got_q;
      end
    end

    if (clr) begin
      mis_d      = 1'b0;
      err_cnt_d  = '0;
      pass_cnt_d = '0;
      err_addr_d = '0;
      err_exp_d  = '0;
      err_got_d  = '0;
      led_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      mode_q     <= PAT_LFSR;
      inv_q      <= 1'b0;
      parity_q   <= 1'b0;
      mis_q      <= 1'b0;
      mis_idx_q  <= '0;
      mis_exp_q  <= '0;
      mis_got_q  <= '0;
      err_cnt_q  <= '0;
      pass_cnt_q <= '0;
      err_addr_q <= '0;
      err_exp_q  <= '0;
      err_got_q  <= '0;
      led_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mode_q     <= mode_d;
      inv_q      <= inv_d;
      parity_q   <= parity_d;
      mis_q      <= mis_d;
      mis_idx_q  <= mis_idx_d;
      mis_exp_q  <= mis_exp_d;
      mis_got_q  <= mis_got_d;
      err_cnt_q  <= err_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      err_addr_q <= err_addr_d;
      err_exp_q  <= err_exp_d;
      err_got_q  <= err_got_d;
      led_q      <= led_d;
    end
  end

  assign sram_start = in_start;
  assign sram_rnw   = (state_q == ST_RD_START) || (state_q == ST_RD_WAIT);
  // Write data is driven only during the write phase so idle outputs read 0.
  assign sram_wdat  = wr_phase ? gen_data : '0;
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted     = (state_q == ST_HALT);
  assign err_cnt    = err_cnt_q;
  assign pass_cnt   = pass_cnt_q;
  assign err_addr   = err_addr_q;
  assign err_exp    = err_exp_q;
  assign err_got    = err_got_q;
  assign led        = led_q || (err_cnt_q != '0);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_pattern_tester.sv
// Bench for mem_pattern_tester with a behavioural sram_control model
// (16 words of 8 bits) and a write-data scoreboard.
module tb_mem_pattern_tester;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 4;
  localparam int ERRCNT_W  = 2;
  localparam int PASSCNT_W = 16;
  localparam int WORDS     = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 run = 1'b0;
  logic [1:0]           mode = 2'd0;
  logic                 invert_odd = 1'b0;
  logic                 stop_on_err = 1'b0;
  logic                 clr = 1'b0;
  logic                 sram_start, sram_rnw, sram_stop, sram_ready;
  logic [DATA_W-1:0]    sram_wdat, sram_rdat;
  logic                 busy, halted, led;
  logic [ERRCNT_W-1:0]  err_cnt;
  logic [PASSCNT_W-1:0] pass_cnt;
  logic [ADDR_W-1:0]    err_addr;
  logic [DATA_W-1:0]    err_exp, err_got;
  logic [2:0]           dbg_state;

  mem_pattern_tester #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ERRCNT_W(ERRCNT_W),
    .PASSCNT_W(PASSCNT_W), .LFSR_SEED(20'h1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mode(mode), .invert_odd(invert_odd),
    .stop_on_err(stop_on_err), .clr(clr), .sram_start(sram_start), .sram_rnw(sram_rnw),
    .sram_stop(sram_stop), .sram_ready(sram_ready), .sram_wdat(sram_wdat),
    .sram_rdat(sram_rdat), .busy(busy), .halted(halted), .err_cnt(err_cnt),
    .pass_cnt(pass_cnt), .err_addr(err_addr), .err_exp(err_exp), .err_got(err_got),
    .led(led), .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- sram_control model ----------------
  logic [DATA_W-1:0] mem [WORDS];
  logic              m_active, m_rnw;
  logic [ADDR_W-1:0] m_addr;
  int                flip_addr = -1;
  logic              flip_all = 1'b0;

  function automatic logic is_flipped(input logic [ADDR_W-1:0] a);
    return flip_all || (int'(a) == flip_addr);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_rnw <= 1'b0; m_addr <= '0;
      sram_ready <= 1'b0; sram_stop <= 1'b0; sram_rdat <= '0;
    end else begin
      sram_ready <= 1'b0;
      sram_stop  <= 1'b0;
      if (sram_start) begin
        m_active <= 1'b1; m_rnw <= sram_rnw; m_addr <= '0;
      end else if (m_active) begin
        if (sram_ready) begin
          if (!m_rnw) mem[m_addr] <= sram_wdat;
          m_addr <= m_addr + ADDR_W'(1);
          if (sram_stop) m_active <= 1'b0;
        end else if ($urandom_range(0, 3) != 0) begin
          sram_ready <= 1'b1;
          sram_stop  <= (m_addr == ADDR_W'(WORDS - 1));
          sram_rdat  <= mem[m_addr] ^ {7'd0, is_flipped(m_addr)};
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  function automatic logic [7:0] exp_word(input int idx, input logic [1:0] m, input logic inv);
    logic [19:0] lf;
    logic [7:0]  w;
    lf = 20'h1;
    for (int s = 0; s < idx; s++) lf = {lf[18:0], lf[19] ^ lf[16]};
    case (m)
      2'd0:    w = lf[7:0];
      2'd1:    w = 8'(idx);
      2'd2:    w = idx[0] ? 8'h55 : 8'hAA;
      default: w = 8'h01 << (idx % 8);
    endcase
    return inv ? ~w : w;
  endfunction

  logic [DATA_W-1:0] exp_q[$];
  int   wr_starts, rd_starts, bad_cyc;
  logic bad_seen;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      wr_starts <= 0; rd_starts <= 0; bad_cyc <= 0; bad_seen <= 1'b0;
    end else begin
      if (sram_start && !sram_rnw) begin
        for (int i = 0; i < WORDS; i++)
          exp_q.push_back(exp_word(i, mode, invert_odd && wr_starts[0]));
        wr_starts <= wr_starts + 1;
      end
      if (sram_start && sram_rnw) rd_starts <= rd_starts + 1;
      if (sram_ready && m_active && !m_rnw) begin
        if (exp_q.size() == 0) check("wdat_unexpected", 32'(sram_wdat), 32'hFFFF_FFFF);
        else check("wdat", 32'(sram_wdat), 32'(exp_q.pop_front()));
      end
      if (sram_ready && m_active && m_rnw && is_flipped(m_addr) && !bad_seen) begin
        bad_seen <= 1'b1;
        bad_cyc  <= cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; clr = 1'b0; stop_on_err = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_passes(input int n);
    int k;
    run = 1'b1;
    k = 0;
    while (wr_starts < n && k < 3000) begin @(negedge clk); k++; end
    check("pass_started", 32'(wr_starts >= n), 32'd1);
    run = 1'b0;
    k = 0;
    while (busy && k < 3000) begin @(negedge clk); k++; end
    check("idle_after_run", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic        inv;
    int          flip;
    logic        all;
    int          passes;
    logic [31:0] e_err, e_pass, e_addr, e_exp, e_got, e_led;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{2'd1, 1'b0, -1, 1'b0, 2, 0, 2, 0, 8'h00, 8'h00, 0};
    vt[1] = '{2'd2, 1'b1, -1, 1'b0, 2, 0, 2, 0, 8'h00, 8'h00, 0};
    vt[2] = '{2'd3, 1'b0,  5, 1'b0, 2, 2, 2, 5, 8'h20, 8'h21, 1};
    vt[3] = '{2'd0, 1'b0, -1, 1'b0, 2, 0, 2, 0, 8'h00, 8'h00, 0};
    vt[4] = '{2'd0, 1'b0, -1, 1'b1, 1, 3, 1, 0, 8'h01, 8'h00, 1};
    vt[5] = '{2'd1, 1'b1,  7, 1'b0, 2, 2, 2, 7, 8'h07, 8'h06, 1};
    vt[6] = '{2'd3, 1'b1, -1, 1'b0, 3, 0, 3, 0, 8'h00, 8'h00, 1};

    #1;
    check("rst0_ctrl", 32'({sram_start, sram_rnw, busy, halted, led, err_cnt}), 32'd0);
    check("rst0_data", 32'({sram_wdat, err_exp, err_got}), 32'd0);
    check("rst0_cnt", 32'({pass_cnt, err_addr}), 32'd0);

    // ---- table-driven passes ----
    for (int t = 0; t < 7; t++) begin
      do_reset();
      mode = vt[t].mode; invert_odd = vt[t].inv;
      flip_addr = vt[t].flip; flip_all = vt[t].all;
      run_passes(vt[t].passes);
      check($sformatf("t%0d_err_cnt", t), 32'(err_cnt), vt[t].e_err);
      check($sformatf("t%0d_pass_cnt", t), 32'(pass_cnt), vt[t].e_pass);
      check($sformatf("t%0d_err_addr", t), 32'(err_addr), vt[t].e_addr);
      check($sformatf("t%0d_err_exp", t), 32'(err_exp), vt[t].e_exp);
      check($sformatf("t%0d_err_got", t), 32'(err_got), vt[t].e_got);
      check($sformatf("t%0d_led", t), 32'(led), vt[t].e_led);
      check($sformatf("t%0d_halted", t), 32'(halted), 32'd0);
      if (t == 0)
        for (int a = 0; a < WORDS; a++) check("mem_addr_data", 32'(mem[a]), 32'(a));
    end

    // ---- stop_on_err, halt latency, clr ----
    do_reset();
    mode = 2'd3; invert_odd = 1'b0; flip_addr = 5; flip_all = 1'b0; stop_on_err = 1'b1;
    run = 1'b1;
    for (int k = 0; k < 3000 && !halted; k++) @(negedge clk);
    check("halted", 32'(halted), 32'd1);
    check("bad_seen", 32'(bad_seen), 32'd1);
    check("halt_latency", 32'(cyc - bad_cyc), 32'd2);
    run = 1'b0;
    repeat (5) @(negedge clk);
    check("halt_sticky", 32'({halted, busy}), 32'b10);
    check("halt_err_cnt", 32'(err_cnt), 32'd1);
    check("halt_capture", 32'({err_addr, err_exp, err_got}), {12'd0, 4'd5, 8'h20, 8'h21});
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_state", 32'({halted, busy, dbg_state}), 32'd0);
    check("clr_counts", 32'({err_cnt, pass_cnt, err_addr, led}), 32'd0);

    // ---- run dropped mid-write, saturating counter ----
    do_reset();
    mode = 2'd0; flip_addr = -1; flip_all = 1'b1;
    run = 1'b1;
    for (int k = 0; k < 100 && wr_starts < 1; k++) @(negedge clk);
    repeat (10) @(negedge clk);
    run = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_after_drop", 32'(busy), 32'd1);
    for (int k = 0; k < 3000 && busy; k++) @(negedge clk);
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_pass_cnt", 32'(pass_cnt), 32'd1);
    check("drop_err_sat", 32'(err_cnt), 32'd3);

    // ---- async reset during read ----
    do_reset();
    mode = 2'd1; flip_all = 1'b1;
    run = 1'b1;
    for (int k = 0; k < 3000 && rd_starts < 1; k++) @(negedge clk);
    repeat (8) @(negedge clk);
    check("pre_reset_rd", 32'({sram_rnw, busy, err_cnt != '0}), 32'b111);
    #2 rst_n = 1'b0; run = 1'b0;
    #1;
    check("arst_ctrl", 32'({sram_start, sram_rnw, busy, halted, led, err_cnt}), 32'd0);
    check("arst_data", 32'({sram_wdat, err_exp, err_got}), 32'd0);
    check("arst_cnt", 32'({pass_cnt, err_addr}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run = 1'b1;
    for (int k = 0; k < 20 && !sram_start; k++) @(negedge clk);
    check("restart_pulse", 32'({sram_start, sram_rnw}), 32'b10);
    @(negedge clk);
    check("restart_one_cycle", 32'({sram_start, busy}), 32'b01);
    run = 1'b0;
    for (int k = 0; k < 3000 && busy; k++) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
